irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NIRQ, default 6, number of interrupt source lines (1..8).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 SHALL have port irq_in  input  NIRQ  level requests from devices (timer IRQ on bit 0); index 0 is highest priority.
REQ-005 SHALL have port Addr  input  2 ([3:2])  register select: 00 CTRL, 01 MASK, 10 PEND, 11 VEC/EOI.
REQ-006 SHALL have port We  input  1  register write strobe, sampled on clk.
REQ-007 SHALL have port DataIn  input  32  write data.
REQ-008 SHALL have port DataOut  output  32  combinational read of the selected register; unused bits read 0.
REQ-009 SHALL have port IntReq  output  1  registered interrupt request to CPU/CP0.
REQ-010 SHALL have port IntAck  input  1  one-cycle CPU acknowledge pulse.

Function
REQ-011 SHALL hold registers CTRL (bit0 GE, global enable), MASK[NIRQ-1:0], PEND[NIRQ-1:0], INSVC index[2:0] with valid bit.
REQ-012 SHALL set PEND[i] on the clk edge where irq_in[i] qualifies (REQ-030/031); PEND visible on DataOut next cycle.
REQ-013 SHALL clear PEND[i] on a write to Addr 10 with DataIn[i]=1 (write-1-to-clear); same-cycle set and clear of one bit: set wins.
REQ-014 SHALL write CTRL/MASK on We at Addr 00/01; write to Addr 11 is End-Of-Interrupt (EOI), data ignored.
REQ-015 SHALL read Addr 11 as {valid at bit31, INSVC index at bits 2:0}.
REQ-016 SHALL define eligible = PEND & MASK; winner = lowest set index of eligible.
REQ-017 SHALL implement FSM IDLE, REQ, SERVE; IntReq=1 only in REQ.
REQ-018 SHALL go IDLE->REQ when GE=1 and eligible!=0; IntReq rises one cycle after eligible becomes non-zero.
REQ-019 SHALL go REQ->IDLE without service if eligible becomes 0 or GE cleared before IntAck.
REQ-020 SHALL, on IntAck in REQ, capture winner (evaluated that cycle) into INSVC, set valid, clear that PEND bit, go SERVE.
REQ-021 SHALL ignore IntAck in IDLE and SERVE.
REQ-022 SHALL stay in SERVE (no new IntReq, nesting disabled) until EOI; EOI clears valid and returns to IDLE; a re-request follows one cycle later if eligible!=0.
REQ-023 SHALL continue to latch PEND in all states, including while GE=0.
REQ-024 SHALL give We priority over nothing else: register writes and FSM advance in the same cycle both take effect, FSM using pre-write values.

Reset
REQ-025 SHALL on reset assertion, asynchronously: CTRL=0, MASK=0, PEND=0, INSVC=0, valid=0, FSM=IDLE, IntReq=0, edge history=0.
REQ-026 SHALL abort any in-flight REQ/SERVE on reset mid-operation; no IntReq after reset deassertion until GE and MASK are rewritten.
REQ-027 SHALL make DataOut reflect reset register values (0) during reset.

Configuration
REQ-028 SHALL support macro IRQ_CTRL_EDGE_EN selecting pending-capture mode.
REQ-029 SHALL keep the register map and FSM identical in both modes.
REQ-030 SHALL, with IRQ_CTRL_EDGE_EN defined, set PEND[i] only on a 0->1 transition of irq_in[i] (one-cycle history register); a held-high line sets PEND once.
REQ-031 SHALL, without IRQ_CTRL_EDGE_EN, set PEND[i] every cycle irq_in[i]=1 (level); W1C while line high is re-set next cycle.

Verification
REQ-032 SHALL verify: GE=1, MASK=0x01, irq_in[0] rises -> PEND=0x01 next cycle, IntReq=1 following cycle.
REQ-033 SHALL verify: MASK=0x3F, irq_in=0x24 -> IntAck gives VEC=0x80000002, PEND=0x20, IntReq=0 until EOI, then IntReq=1 for source 5.
REQ-034 SHALL verify: IntReq=1, software writes MASK=0 -> IntReq=0 next cycle, FSM IDLE, PEND unchanged.
REQ-035 SHALL verify: irq_in[1] held high 10 cycles, W1C PEND=0x02 -> edge build PEND=0, level build PEND=0x02 next cycle.
REQ-036 SHALL verify: reset asserted mid-SERVE between edges -> IntReq, VEC, PEND, CTRL read 0 before next clk edge.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised interrupt controller with CTRL/MASK/PEND/VEC register map and IDLE/REQ/SERVE handshake.
// Define IRQ_CTRL_EDGE_EN to latch PEND on rising edges of irq_in; otherwise PEND is level-latched.
module irq_ctrl #(
    parameter int NIRQ = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_in,
    input  logic [1:0]      Addr,
    input  logic            We,
    input  logic [31:0]     DataIn,
    output logic [31:0]     DataOut,
    output logic            IntReq,
    input  logic            IntAck
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVE} state_t;

    state_t          r_state, w_next;
    logic            r_ge, r_valid, r_intreq, w_ack, w_eoi, w_unused;
    logic [NIRQ-1:0] r_mask, r_pend, w_elig, w_set, w_w1c, w_ack_clr;
    logic [2:0]      r_insvc, w_win;

    assign w_elig   = r_pend & r_mask;
    assign w_eoi    = We && Addr == 2'b11;
    assign w_w1c    = (We && Addr == 2'b10) ? DataIn[NIRQ-1:0] : '0;
    assign IntReq   = r_intreq;
    assign w_unused = ^DataIn;

`ifdef IRQ_CTRL_EDGE_EN
    logic [NIRQ-1:0] r_hist;
    assign w_set = irq_in & ~r_hist;
    // one-cycle history of the request lines for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_hist <= '0;
        else       r_hist <= irq_in;
    end
`else
    assign w_set = irq_in;
`endif

    // lowest eligible index wins; ack clears only that pending bit
    always_comb begin
        w_win     = '0;
        w_ack_clr = '0;
        for (int i = NIRQ - 1; i >= 0; i--)
            if (w_elig[i]) w_win = 3'(i);
        for (int i = 0; i < NIRQ; i++)
            w_ack_clr[i] = w_ack && w_win == 3'(i);
    end

    // next-state: abort a request when it loses eligibility, otherwise serve on ack until EOI
    always_comb begin
        w_next = r_state;
        w_ack  = 1'b0;
        case (r_state)
            S_IDLE:  if (r_ge && |w_elig) w_next = S_REQ;
            S_REQ:   if (!r_ge || ~|w_elig) w_next = S_IDLE;
                     else if (IntAck) begin
                         w_next = S_SERVE;
                         w_ack  = 1'b1;
                     end
            S_SERVE: if (w_eoi) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // registers; FSM decisions above use pre-write register values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_intreq <= 1'b0;
            r_ge     <= 1'b0;
            r_mask   <= '0;
            r_pend   <= '0;
            r_insvc  <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_intreq <= w_next == S_REQ;
            r_pend   <= (r_pend & ~w_w1c & ~w_ack_clr) | w_set;
            if (We && Addr == 2'b00) r_ge <= DataIn[0];
            if (We && Addr == 2'b01) r_mask <= DataIn[NIRQ-1:0];
            if (w_ack) begin
                r_insvc <= w_win;
                r_valid <= 1'b1;
            end else if (w_eoi) r_valid <= 1'b0;
        end
    end

    // combinational register read
    always_comb begin
        DataOut = Addr == 2'b00 ? {31'b0, r_ge} :
                  Addr == 2'b01 ? 32'(r_mask) :
                  Addr == 2'b10 ? 32'(r_pend) :
                                  {r_valid, 28'b0, r_insvc};
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios with literal expectations plus randomized traffic against a behavioural model.
module tb_irq_ctrl;
    localparam int NIRQ = 6;
    localparam bit [7:0] NM = 8'h3F;

    logic        clk = 0, reset = 0, We = 0, IntAck = 0, IntReq;
    logic [5:0]  irq_in = 0;
    logic [1:0]  Addr = 0;
    logic [31:0] DataIn = 0, DataOut;
    int          errors = 0, checks = 0;

    irq_ctrl #(.NIRQ(NIRQ)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .Addr(Addr), .We(We),
        .DataIn(DataIn), .DataOut(DataOut), .IntReq(IntReq), .IntAck(IntAck)
    );

    always #5 clk = ~clk;

    // behavioural model: 0 idle, 1 requesting, 2 in service
    bit       m_ge = 0, m_valid = 0;
    bit [7:0] m_mask = 0, m_pend = 0, m_hist = 0, m_el, m_set, m_clr;
    int       m_st = 0, m_idx = 0, m_win;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ge = 0; m_valid = 0; m_mask = 0; m_pend = 0; m_hist = 0; m_st = 0; m_idx = 0;
        end else begin
            m_el = m_pend & m_mask;
            m_win = -1;
            for (int i = 0; i < NIRQ; i++) if (m_el[i] && m_win < 0) m_win = i;
`ifdef IRQ_CTRL_EDGE_EN
            m_set = {2'b0, irq_in} & ~m_hist;
`else
            m_set = {2'b0, irq_in};
`endif
            m_clr = (We && Addr == 2) ? DataIn[7:0] : 8'h0;
            if (m_st == 0) begin
                if (m_ge && m_el != 0) m_st = 1;
            end else if (m_st == 1) begin
                if (!m_ge || m_el == 0) m_st = 0;
                else if (IntAck) begin
                    m_st = 2; m_idx = m_win; m_valid = 1; m_clr = m_clr | (8'h1 << m_win);
                end
            end else if (We && Addr == 3) begin
                m_st = 0; m_valid = 0;
            end
            m_pend = ((m_pend & ~m_clr) | m_set) & NM;
            if (We && Addr == 0) m_ge = DataIn[0];
            if (We && Addr == 1) m_mask = DataIn[7:0] & NM;
            m_hist = {2'b0, irq_in};
        end
    end

    function automatic logic [31:0] exp_dout(input logic [1:0] a);
        return a == 0 ? {31'b0, m_ge} : a == 1 ? {24'b0, m_mask} : a == 2 ? {24'b0, m_pend} :
               {m_valid, 28'b0, 3'(m_idx)};
    endfunction

    // every cycle: DUT outputs must match the model
    always @(negedge clk) begin
        checks++;
        if (DataOut !== exp_dout(Addr) || IntReq !== (m_st == 1)) begin
            errors++;
            $display("FAIL model t=%0t addr=%0d dout=%h exp=%h intreq=%b exp=%b",
                     $time, Addr, DataOut, exp_dout(Addr), IntReq, m_st == 1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a; DataIn = d; We = 1; step(); We = 0;
    endtask

    task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        Addr = a; #1; chk(name, DataOut, exp);
    endtask

    initial begin
        #1 reset = 1;
        @(posedge clk); #1;
        chk("reset_intreq", {31'b0, IntReq}, 0);
        rd("reset_pend", 2, 0);
        @(posedge clk); #2 reset = 0;

        // first request: pending then IntReq one cycle later
        wr(0, 1); wr(1, 1);
        irq_in = 6'h01; step();
        rd("s1_pend", 2, 32'h1);
        chk("s1_intreq_early", {31'b0, IntReq}, 0);
        step();
        chk("s1_intreq", {31'b0, IntReq}, 1);
        IntAck = 1; step(); IntAck = 0;
        rd("s1_vec", 3, 32'h80000000);
        chk("s1_serve_intreq", {31'b0, IntReq}, 0);
        irq_in = 0; wr(2, 32'hFF); wr(3, 0); step();
        chk("s1_after_eoi", {31'b0, IntReq}, 0);
        rd("s1_vec_eoi", 3, 32'h0);

        // two sources: priority, no nesting, re-request after EOI
        wr(1, 32'h3F);
        irq_in = 6'h24; step(); irq_in = 0;
        rd("s2_pend", 2, 32'h24);
        step();
        chk("s2_intreq", {31'b0, IntReq}, 1);
        IntAck = 1; step(); IntAck = 0;
        rd("s2_vec", 3, 32'h80000002);
        rd("s2_pend_after_ack", 2, 32'h20);
        chk("s2_serve_intreq", {31'b0, IntReq}, 0);
        repeat (3) step();
        chk("s2_still_serve", {31'b0, IntReq}, 0);
        wr(3, 0);
        chk("s2_eoi_cycle", {31'b0, IntReq}, 0);
        step();
        chk("s2_rereq", {31'b0, IntReq}, 1);
        IntAck = 1; step(); IntAck = 0;
        rd("s2_vec5", 3, 32'h80000005);
        rd("s2_pend_empty", 2, 32'h0);
        wr(3, 0); step();

        // mask write withdraws a request
        irq_in = 6'h08; step(); irq_in = 0; step();
        chk("s3_intreq", {31'b0, IntReq}, 1);
        wr(1, 0);
        chk("s3_write_cycle", {31'b0, IntReq}, 1);
        step();
        chk("s3_withdrawn", {31'b0, IntReq}, 0);
        rd("s3_pend_kept", 2, 32'h08);
        chk("s3_not_valid", {31'b0, DataOut[31]}, 0);
        wr(2, 32'hFF);

        // W1C against a held line
        irq_in = 6'h02; repeat (10) step();
        rd("s4_pend_held", 2, 32'h02);
        wr(2, 32'h02);
`ifdef IRQ_CTRL_EDGE_EN
        rd("s4_pend_w1c", 2, 32'h0);
`else
        rd("s4_pend_w1c", 2, 32'h02);
`endif
        irq_in = 0; wr(2, 32'hFF);

        // reset in the middle of service
        wr(1, 32'h3F);
        irq_in = 6'h10; step(); irq_in = 0; step();
        IntAck = 1; step(); IntAck = 0;
        irq_in = 6'h01; step(); irq_in = 0;
        rd("s5_vec", 3, 32'h80000004);
        reset = 1; #1;
        chk("s5_rst_intreq", {31'b0, IntReq}, 0);
        for (int a = 0; a < 4; a++) begin
            Addr = 2'(a); #1;
            chk($sformatf("s5_rst_reg%0d", a), DataOut, 0);
        end
        step(); reset = 0;
        irq_in = 6'h3F; repeat (3) step();
        chk("s5_no_req_after_rst", {31'b0, IntReq}, 0);
        rd("s5_pend", 2, 32'h3F);
        irq_in = 0; wr(2, 32'hFF);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299) == 0) begin
                reset = 1; step(); reset = 0;
            end
            irq_in = irq_in ^ 6'($urandom_range(63) & $urandom_range(63) & $urandom_range(63));
            We = $urandom_range(3) == 0;
            Addr = 2'($urandom_range(3));
            DataIn = $urandom;
            IntAck = $urandom_range(3) == 0;
            step();
        end
        We = 0; IntAck = 0; step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
